rom_read_arbiter: RTL and testbench
===================================

Name: rom_read_arbiter

Overview:
Two-port read arbiter that shares a single asynchronous 4x4 ROM (combinational address-to-data) between two requesters. It grants access round-robin, drives a registered ROM address, and captures ROM data one cycle later into a registered output. It returns a one-cycle valid pulse to the winning requester. It sits between the ROM instance and the client logic, so the ROM address is never driven by two sources.

Parameters:
ADDR_W, 2, ROM address width (ROM depth = 2**ADDR_W)
DATA_W, 4, ROM word width

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst  input  1  synchronous reset, active-high
req0  input  1  requester 0 read request (level)
addr0  input  ADDR_W  requester 0 read address
req1  input  1  requester 1 read request (level)
addr1  input  ADDR_W  requester 1 read address
rom_addr  output  ADDR_W  registered address to the ROM
rom_data  input  DATA_W  combinational ROM data for rom_addr
rdata  output  DATA_W  captured read data, shared by both requesters
valid0  output  1  one-cycle pulse: rdata belongs to requester 0
valid1  output  1  one-cycle pulse: rdata belongs to requester 1
busy  output  1  high when state is not IDLE

Behaviour:
- Reset (rst high at a rising edge): state=IDLE, rom_addr=0, rdata=0, valid0=valid1=0, busy=0, last_grant=1 (so requester 0 wins the first contention).
- FSM states:
  - IDLE: sample req0/req1 each cycle.
    - Neither high: stay in IDLE.
    - Exactly one high: grant it.
    - Both high: grant the requester that is not last_grant.
    - On grant: rom_addr<=addrX, gnt<=X, state<=READ.
  - READ: rdata<=rom_data, validX<=1 for gnt, last_grant<=gnt, state<=DONE.
  - DONE: validX is high for exactly this cycle; req inputs are ignored. Next edge: valid cleared, state<=IDLE.
- Latency: req sampled high at edge k, then valid and rdata are visible during cycle k+2 (two edges after the sampling edge). Sustained throughput is one read per 3 cycles.
- Handshake: the requester holds req and addr stable until it sees its valid, then drops req in the DONE cycle. If req is still high in IDLE after DONE, it is a new read. Per-requester handshakes are independent.
- Address is captured only at grant. addrX changes after grant do not affect the in-flight read.
- rdata holds its last value between reads. valid0 and valid1 are never high together.
- Fairness: with both requesters asserting continuously, grants strictly alternate 0,1,0,1,...
- Single requester repeatedly: it is granted every 3 cycles regardless of last_grant.
- A req that rises while busy is serviced at the next IDLE, subject to round-robin.
- Reset mid-operation (READ or DONE):
  - The in-flight read is abandoned and no valid pulse is issued.
  - All outputs take reset values on that edge; last_grant returns to 1.
- busy is combinational from state (state != IDLE). It has no reset glitch since state is registered.
- Widths: rom_addr and rdata are exactly ADDR_W and DATA_W. No arithmetic except the single-bit round-robin toggle.

Test Plan:
Bench ROM model contents: addr0=4'hA, addr1=4'h5, addr2=4'hC, addr3=4'h3. Each scenario is applied after a 2-cycle reset.
1. Single read: req0=1, addr0=2 for one sample -> rom_addr=2 next cycle; valid0=1, rdata=4'hC two edges after sampling; valid1 stays 0; busy high for 2 cycles.
2. Simultaneous first request: req0=1/addr0=1, req1=1/addr1=3 -> requester 0 served first (valid0, rdata=4'h5), then requester 1 (valid1, rdata=4'h3) 3 cycles later.
3. Sustained contention for 12 cycles: both req held, valids deasserted only by DONE -> valid sequence 0,1,0,1 at 3-cycle spacing; never both valid high together.
4. Address change after grant: req1=1/addr1=0 granted, then addr1 changes to 3 during READ -> rdata=4'hA (captured address used).
5. Reset mid-read: req0=1/addr0=3, assert rst in the READ cycle -> no valid pulse; rdata=0, rom_addr=0, busy=0. After release, a req1 read returns normally, and the next contention grants requester 0 first.
6. Idle hold: no requests for 10 cycles after a read of addr 2 -> rdata holds 4'hC, busy=0, rom_addr unchanged.

Source files
------------

// File: rtl/rom_read_arbiter.sv
// Round-robin read arbiter sharing one combinational ROM between two requesters.
// The winning address is registered onto rom_addr, and the ROM word is captured one
// cycle later. A single-cycle valid pulse goes to the requester that won.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | sampling req0/req1; a grant latches the address and the winner
// READ  | rom_addr is stable; capture rom_data and raise the winner's valid
// DONE  | valid is high for this cycle only; requests are ignored
module rom_read_arbiter #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] rdata,
    output logic              valid0,
    output logic              valid1,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        READ = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t state, state_nxt;
    logic   gnt;
    logic   last_grant;
    logic   grant_valid;
    logic   grant_sel;

    // Next state and grant decision; on contention the requester that was not served last wins.
    always_comb begin
        state_nxt   = state;
        grant_valid = 1'b0;
        grant_sel   = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    grant_valid = 1'b1;
                    grant_sel   = req1 && (!req0 || !last_grant);
                    state_nxt   = READ;
                end
            end
            READ:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Datapath: the address is latched only at grant, so address changes after grant
    // cannot disturb the read in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr   <= '0;
            gnt        <= 1'b0;
            last_grant <= 1'b1;
            rdata      <= '0;
            valid0     <= 1'b0;
            valid1     <= 1'b0;
        end else begin
            valid0 <= 1'b0;
            valid1 <= 1'b0;
            if (grant_valid) begin
                rom_addr <= grant_sel ? addr1 : addr0;
                gnt      <= grant_sel;
            end
            if (state == READ) begin
                rdata      <= rom_data;
                valid0     <= !gnt;
                valid1     <= gnt;
                last_grant <= gnt;
            end
        end
    end

    // busy is decoded from the registered state, so it cannot glitch.
    always_comb busy = (state != IDLE);

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Scoreboard bench for rom_read_arbiter. Stimulus pushes the expected requester and
// data for each read. A monitor forked beside the stimulus pops and compares these
// whenever a valid pulse appears.
module tb_rom_read_arbiter;

    logic       clk;
    logic       rst;
    logic       req0, req1;
    logic [1:0] addr0, addr1;
    logic [1:0] rom_addr;
    logic [3:0] rom_data;
    logic [3:0] rdata;
    logic       valid0, valid1, busy;

    typedef struct packed {
        logic       who;
        logic [3:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_tests;
    int   n_fail;
    int   n;

    rom_read_arbiter #(.ADDR_W(2), .DATA_W(4)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .addr0(addr0),
        .req1(req1), .addr1(addr1),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .rdata(rdata), .valid0(valid0), .valid1(valid1), .busy(busy)
    );

    // ROM model: A, 5, C, 3
    always_comb begin
        case (rom_addr)
            2'd0:    rom_data = 4'hA;
            2'd1:    rom_data = 4'h5;
            2'd2:    rom_data = 4'hC;
            default: rom_data = 4'h3;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic who, input logic [3:0] data);
        exp_t e;
        e.who  = who;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rom_addr", int'(rom_addr), 0);
        chk("rst_rdata", int'(rdata), 0);
        chk("rst_valids", int'({valid0, valid1}), 0);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b0;
    endtask

    // Waits (bounded) for the given requester's valid, counting edges.
    task automatic wait_valid(input int which, input int budget, output int cnt);
        logic seen;
        seen = 1'b0;
        cnt  = 0;
        while (!seen && cnt < budget) begin
            @(posedge clk);
            #1;
            cnt++;
            seen = (which == 0) ? valid0 : valid1;
        end
        if (!seen) chk("timeout_valid", which, -1);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        req0    = 1'b0;
        req1    = 1'b0;
        addr0   = 2'd0;
        addr1   = 2'd0;

        fork
            // Monitor: compares every valid pulse against the scoreboard head.
            forever begin
                exp_t e;
                @(negedge clk);
                if (valid0 && valid1) begin
                    chk("both_valid", 1, 0);
                end else if (valid0 || valid1) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_valid", int'(valid1), -1);
                    end else begin
                        e = sb.pop_front();
                        chk("sb_who", int'(valid1), int'(e.who));
                        chk("sb_data", int'(rdata), int'(e.data));
                    end
                end
            end
        join_none

        // 1: single read of addr 2
        do_reset();
        push(1'b0, 4'hC);
        req0 = 1'b1; addr0 = 2'd2;
        @(posedge clk); #1;
        chk("s1_rom_addr", int'(rom_addr), 2);
        chk("s1_busy_read", int'(busy), 1);
        req0 = 1'b0;
        @(posedge clk); #1;
        chk("s1_busy_done", int'(busy), 1);
        chk("s1_valid0", int'(valid0), 1);
        chk("s1_valid1", int'(valid1), 0);
        chk("s1_rdata", int'(rdata), 12);
        @(posedge clk); #1;
        chk("s1_busy_idle", int'(busy), 0);
        chk("s1_valid0_clr", int'(valid0), 0);

        // 2: simultaneous first request, requester 0 wins
        do_reset();
        push(1'b0, 4'h5);
        push(1'b1, 4'h3);
        req0 = 1'b1; addr0 = 2'd1;
        req1 = 1'b1; addr1 = 2'd3;
        wait_valid(0, 10, n);
        chk("s2_lat0", n, 2);
        req0 = 1'b0;
        wait_valid(1, 10, n);
        chk("s2_gap1", n, 3);
        req1 = 1'b0;
        @(posedge clk); #1;

        // 3: sustained contention for 12 cycles -> 0,1,0,1 every 3 cycles
        do_reset();
        push(1'b0, 4'h5);
        push(1'b1, 4'h3);
        push(1'b0, 4'h5);
        push(1'b1, 4'h3);
        req0 = 1'b1; addr0 = 2'd1;
        req1 = 1'b1; addr1 = 2'd3;
        for (int i = 1; i <= 12; i++) begin
            logic [1:0] exp_v;
            @(posedge clk); #1;
            case (i)
                2, 8:    exp_v = 2'b10;
                5, 11:   exp_v = 2'b01;
                default: exp_v = 2'b00;
            endcase
            chk($sformatf("s3_valids_c%0d", i), int'({valid0, valid1}), int'(exp_v));
        end
        req0 = 1'b0;
        req1 = 1'b0;
        @(posedge clk); #1;

        // 4: address change after grant does not affect the read
        do_reset();
        push(1'b1, 4'hA);
        req1 = 1'b1; addr1 = 2'd0;
        @(posedge clk); #1;
        addr1 = 2'd3;
        wait_valid(1, 10, n);
        chk("s4_lat", n, 1);
        chk("s4_rdata", int'(rdata), 10);
        req1 = 1'b0;
        @(posedge clk); #1;

        // 5: reset during READ abandons the read
        do_reset();
        req0 = 1'b1; addr0 = 2'd3;
        @(posedge clk); #1;
        chk("s5_busy_read", int'(busy), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("s5_valid0", int'(valid0), 0);
        chk("s5_rdata", int'(rdata), 0);
        chk("s5_rom_addr", int'(rom_addr), 0);
        chk("s5_busy", int'(busy), 0);
        rst  = 1'b0;
        req0 = 1'b0;
        @(posedge clk); #1;
        push(1'b1, 4'hC);
        req1 = 1'b1; addr1 = 2'd2;
        wait_valid(1, 10, n);
        chk("s5_req1_lat", n, 2);
        req1 = 1'b0;
        @(posedge clk); #1;
        push(1'b0, 4'hA);
        push(1'b1, 4'h5);
        req0 = 1'b1; addr0 = 2'd0;
        req1 = 1'b1; addr1 = 2'd1;
        wait_valid(0, 10, n);
        chk("s5_cont_first0", n, 2);
        req0 = 1'b0;
        wait_valid(1, 10, n);
        chk("s5_cont_then1", n, 3);
        req1 = 1'b0;
        @(posedge clk); #1;

        // 6: idle hold after a read of addr 2
        do_reset();
        push(1'b0, 4'hC);
        req0 = 1'b1; addr0 = 2'd2;
        wait_valid(0, 10, n);
        req0 = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            chk("s6_busy", int'(busy), 0);
        end
        chk("s6_rdata_hold", int'(rdata), 12);
        chk("s6_rom_addr_hold", int'(rom_addr), 2);

        @(posedge clk); #1;
        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
